nested_ifs_cfg_loader: RTL and testbench
========================================

# nested_ifs_cfg_loader

Configuration loader that sits directly upstream of the `nested_ifs` stateful atom and drives all of its `i__cons_*`, `i__sel_*` and `i__rel_op*` inputs. It accepts a 13-word configuration image over a 32-bit valid/ready stream and assembles it in shadow registers. On a well-formed image it commits all fields to the active registers in a single cycle, so the atom never sees a partially updated configuration. Malformed images are discarded and flagged.

## Interface
- No parameters; the image length is fixed at 13 words by the atom's field set.
- `clk` in 1: rising-edge clock, shared with the atom.
- `rst_n` in 1: asynchronous, active-low reset.
- `i__cfg_data` in 32: configuration word.
- `i__cfg_valid` in 1: `i__cfg_data` and `i__cfg_last` are valid.
- `i__cfg_last` in 1: marks the final word of an image.
- `o__cfg_ready` out 1: loader can accept a word this cycle.
- `o__cfg_done` out 1: one-cycle pulse; a new configuration is active.
- `o__cfg_err` out 1: one-cycle pulse; the image was discarded.
- `o__cfg_busy` out 1: an image is partially loaded or committing.
- `o__cfg_epoch` out 8: count of successful commits, wraps at 255→0.
- `o__cons_1` … `o__cons_11` out 32 each: active constants.
- `o__sel_1`–`o__sel_7`, `o__sel_10`, `o__sel_13`–`o__sel_16`, `o__sel_19` out 1 each: active 2-way mux selects.
- `o__sel_8`, `o__sel_9`, `o__sel_11`, `o__sel_12`, `o__sel_17`, `o__sel_18`, `o__sel_20`, `o__sel_21` out 2 each: active 3-way mux selects.
- `o__rel_op1`–`o__rel_op3` out 2 each: active relational opcodes.

## Operation
- **Image layout** (word index k = order of acceptance):
  - k=0..10: `cons_(k+1)`.
  - k=11, bits [12:0]: 1-bit selects in order `sel_1`, `sel_2`, `sel_3`, `sel_4`, `sel_5`, `sel_6`, `sel_7`, `sel_10`, `sel_13`, `sel_14`, `sel_15`, `sel_16`, `sel_19`, with bit 0 = `sel_1`.
  - k=11, bits [28:13]: 2-bit selects in order `sel_8`, `sel_9`, `sel_11`, `sel_12`, `sel_17`, `sel_18`, `sel_20`, `sel_21`. `sel_8` occupies [14:13]; each next field sits 2 bits higher.
  - k=11, bits [31:29]: ignored.
  - k=12: `rel_op1` in [1:0], `rel_op2` in [3:2], `rel_op3` in [5:4]; bits [31:6] ignored.
- **Handshake:** a word transfers on a rising edge where `i__cfg_valid && o__cfg_ready`.
- **Index counter:** 4-bit word index counter `idx`. Each accepted word is written to the shadow field for `idx`, then `idx` increments.
- **FSM states:**
  - IDLE: `idx`=0, ready=1. An accepted word moves the FSM to LOAD, except the error case below.
  - LOAD: ready=1.
  - COMMIT: ready=0, lasts exactly one cycle. On exit: active←shadow, epoch+1, done pulses, `idx`←0, next state IDLE.
- **FSM transitions out of LOAD:**
  - Accept with `idx`=12 and `last`=1 → COMMIT.
  - Accept with `last`=1 and `idx`<12 → error.
  - Accept with `idx`=12 and `last`=0 → error.
- **IDLE error case:** an accepted word with `last`=1 is an error. A 1-word image is always malformed.
- **Error handling:** the offending word is dropped, `idx`←0, state→IDLE, `o__cfg_err` pulses. Shadow contents become don't-care. Active registers and epoch are unchanged.
- **Busy:** `o__cfg_busy` = (state ≠ IDLE).
- **Active registers:** change only on the COMMIT edge, never mid-image.
- **Reset (any time, including mid-load or in COMMIT):**
  - State IDLE, `idx`=0.
  - All shadow and active registers 0, epoch 0.
  - done=0, err=0, busy=0, ready=1 after release.
  - All-zero active configuration is the defined atom default: every mux selects its first input and every `rel_op` is opcode 0 (!=).

## Timing
- **Commit latency:** call the last-word handshake edge E.
  - COMMIT is the cycle after E.
  - New active outputs appear after edge E+1.
  - `o__cfg_done` is high for exactly the cycle following E+1, aligned with the new outputs and the new epoch.
- **Error latency:** `o__cfg_err` is high for exactly one cycle, the cycle following the offending handshake edge.
- **Next image:** its first word may be accepted in the cycle after COMMIT, i.e. the done cycle. This gives minimum back-to-back throughput of one image per 14 cycles.
- **Flow control:** `o__cfg_ready` is a registered function of state only. It has no combinational path from `i__cfg_valid`.
- **Clean outputs:** all outputs are registered; no combinational input→output paths.
- **Stalls:** valid may deassert mid-image for any number of cycles; `idx` holds.

## Test plan
- **Reset:** assert `rst_n`=0 mid-stream → all `o__cons_*`/`o__sel_*`/`o__rel_op*`=0, epoch=0, ready=1, busy=0 after release.
- **Full image:** cons k=0..10 = 0x100+k, word11=0x1FFFFFFF, word12=0x39, last on word 12 → done one cycle after COMMIT. Required outputs:
  - `o__cons_1`=0x100, `o__cons_11`=0x10A.
  - All 1-bit sels=1, all 2-bit sels=3.
  - `rel_op1`=1, `rel_op2`=2, `rel_op3`=3.
  - epoch=1.
- **Early last:** `last`=1 on word 5 → err pulse one cycle later; prior active config and epoch unchanged. A following good image commits normally.
- **Missing last:** 13 words with `last`=0 → err on word 12. Outputs unchanged and `idx` back to 0, so the 14th word is taken as k=0.
- **Stalls and reset mid-load:** random `valid` gaps inside an image still commit correct values. Asserting `rst_n` at k=7 → all-zero config; the next full image then commits with epoch=1.
- **Back-to-back and wrap:** 256 back-to-back images, next first word presented during the done cycle → ready=0 only in each COMMIT cycle, and epoch wraps 255→0 on the 256th commit.

Source files
------------

// File: rtl/nested_ifs_cfg_loader.sv
// Configuration loader for the nested_ifs atom: assembles a 13-word image in
// shadow registers and commits every field to the active registers in a
// single cycle. Malformed images are dropped and flagged with a one-cycle
// error pulse. All outputs come straight from flops.
module nested_ifs_cfg_loader (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i__cfg_data,
  input  logic        i__cfg_valid,
  input  logic        i__cfg_last,
  output logic        o__cfg_ready,
  output logic        o__cfg_done,
  output logic        o__cfg_err,
  output logic        o__cfg_busy,
  output logic [7:0]  o__cfg_epoch,
  output logic [31:0] o__cons_1,
  output logic [31:0] o__cons_2,
  output logic [31:0] o__cons_3,
  output logic [31:0] o__cons_4,
  output logic [31:0] o__cons_5,
  output logic [31:0] o__cons_6,
  output logic [31:0] o__cons_7,
  output logic [31:0] o__cons_8,
  output logic [31:0] o__cons_9,
  output logic [31:0] o__cons_10,
  output logic [31:0] o__cons_11,
  output logic        o__sel_1,
  output logic        o__sel_2,
  output logic        o__sel_3,
  output logic        o__sel_4,
  output logic        o__sel_5,
  output logic        o__sel_6,
  output logic        o__sel_7,
  output logic [1:0]  o__sel_8,
  output logic [1:0]  o__sel_9,
  output logic        o__sel_10,
  output logic [1:0]  o__sel_11,
  output logic [1:0]  o__sel_12,
  output logic        o__sel_13,
  output logic        o__sel_14,
  output logic        o__sel_15,
  output logic        o__sel_16,
  output logic [1:0]  o__sel_17,
  output logic [1:0]  o__sel_18,
  output logic        o__sel_19,
  output logic [1:0]  o__sel_20,
  output logic [1:0]  o__sel_21,
  output logic [1:0]  o__rel_op1,
  output logic [1:0]  o__rel_op2,
  output logic [1:0]  o__rel_op3
);

  localparam int unsigned NUM_CONS = 11;
  localparam logic [3:0]  SEL_IDX  = 4'd11;
  localparam logic [3:0]  LAST_IDX = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMMIT
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  epoch_q, epoch_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        accept;
  logic        commit;

  // Shadow image being assembled, and the configuration the atom sees.
  // Word 11 carries 13 one-bit selects in [12:0] and 8 two-bit selects in
  // [28:13]; word 12 carries the three relational opcodes in [5:0].
  logic [31:0] shd_cons_q [NUM_CONS];
  logic [28:0] shd_sel_q;
  logic [5:0]  shd_rel_q;
  logic [31:0] act_cons_q [NUM_CONS];
  logic [28:0] act_sel_q;
  logic [5:0]  act_rel_q;

  // ready is a flop, so the handshake has no combinational path from valid.
  assign accept = i__cfg_valid && ready_q;

  // Next-state, index, epoch and pulse logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    epoch_d = epoch_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (i__cfg_last) begin
            // A one-word image can never be complete.
            err_d = 1'b1;
            idx_d = 4'd0;
          end else begin
            state_d = ST_LOAD;
            idx_d   = idx_q + 4'd1;
          end
        end
      end
      ST_LOAD: begin
        if (accept) begin
          if (idx_q == LAST_IDX && i__cfg_last) begin
            state_d = ST_COMMIT;
            idx_d   = 4'd0;
          end else if (idx_q == LAST_IDX || i__cfg_last) begin
            // Early or missing last: drop the image, keep the active config.
            state_d = ST_IDLE;
            idx_d   = 4'd0;
            err_d   = 1'b1;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        idx_d   = 4'd0;
        epoch_d = epoch_q + 8'd1;
        done_d  = 1'b1;
        commit  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 4'd0;
      end
    endcase
    // Registered flags derived from the next state line up with it exactly.
    ready_d = (state_d != ST_COMMIT);
    busy_d  = (state_d != ST_IDLE);
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      epoch_q <= 8'd0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
      idx_q   <= idx_d;
      epoch_q <= epoch_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Shadow capture: each accepted word lands in the field selected by idx.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these register arrays are reset explicitly because an all-zero
      // configuration is the atom's defined default; a plain storage RAM
      // would normally be left unreset.
      for (int k = 0; k < NUM_CONS; k++) shd_cons_q[k] <= '0;
      shd_sel_q <= '0;
      shd_rel_q <= '0;
    end else if (accept) begin
      for (int k = 0; k < NUM_CONS; k++) begin
        if (idx_q == 4'(k)) shd_cons_q[k] <= i__cfg_data;
      end
      if (idx_q == SEL_IDX)  shd_sel_q <= i__cfg_data[28:0];
      if (idx_q == LAST_IDX) shd_rel_q <= i__cfg_data[5:0];
    end
  end

  // Active configuration: moves as one unit on the COMMIT edge only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CONS; k++) act_cons_q[k] <= '0;
      act_sel_q <= '0;
      act_rel_q <= '0;
    end else if (commit) begin
      for (int k = 0; k < NUM_CONS; k++) act_cons_q[k] <= shd_cons_q[k];
      act_sel_q <= shd_sel_q;
      act_rel_q <= shd_rel_q;
    end
  end

  assign o__cfg_ready = ready_q;
  assign o__cfg_done  = done_q;
  assign o__cfg_err   = err_q;
  assign o__cfg_busy  = busy_q;
  assign o__cfg_epoch = epoch_q;

  assign o__cons_1  = act_cons_q[0];
  assign o__cons_2  = act_cons_q[1];
  assign o__cons_3  = act_cons_q[2];
  assign o__cons_4  = act_cons_q[3];
  assign o__cons_5  = act_cons_q[4];
  assign o__cons_6  = act_cons_q[5];
  assign o__cons_7  = act_cons_q[6];
  assign o__cons_8  = act_cons_q[7];
  assign o__cons_9  = act_cons_q[8];
  assign o__cons_10 = act_cons_q[9];
  assign o__cons_11 = act_cons_q[10];

  assign o__sel_1  = act_sel_q[0];
  assign o__sel_2  = act_sel_q[1];
  assign o__sel_3  = act_sel_q[2];
  assign o__sel_4  = act_sel_q[3];
  assign o__sel_5  = act_sel_q[4];
  assign o__sel_6  = act_sel_q[5];
  assign o__sel_7  = act_sel_q[6];
  assign o__sel_10 = act_sel_q[7];
  assign o__sel_13 = act_sel_q[8];
  assign o__sel_14 = act_sel_q[9];
  assign o__sel_15 = act_sel_q[10];
  assign o__sel_16 = act_sel_q[11];
  assign o__sel_19 = act_sel_q[12];

  assign o__sel_8  = act_sel_q[14:13];
  assign o__sel_9  = act_sel_q[16:15];
  assign o__sel_11 = act_sel_q[18:17];
  assign o__sel_12 = act_sel_q[20:19];
  assign o__sel_17 = act_sel_q[22:21];
  assign o__sel_18 = act_sel_q[24:23];
  assign o__sel_20 = act_sel_q[26:25];
  assign o__sel_21 = act_sel_q[28:27];

  assign o__rel_op1 = act_rel_q[1:0];
  assign o__rel_op2 = act_rel_q[3:2];
  assign o__rel_op3 = act_rel_q[5:4];

endmodule

// File: tb/tb_nested_ifs_cfg_loader.sv
// Directed testbench for nested_ifs_cfg_loader. Inputs are driven and outputs
// sampled on the falling edge; expected values are hand-derived constants.
module tb_nested_ifs_cfg_loader;

  logic        clk;
  logic        rst_n;
  logic [31:0] cfg_data;
  logic        cfg_valid;
  logic        cfg_last;

  logic        o__cfg_ready, o__cfg_done, o__cfg_err, o__cfg_busy;
  logic [7:0]  o__cfg_epoch;
  logic [31:0] o__cons_1, o__cons_2, o__cons_3, o__cons_4, o__cons_5, o__cons_6;
  logic [31:0] o__cons_7, o__cons_8, o__cons_9, o__cons_10, o__cons_11;
  logic        o__sel_1, o__sel_2, o__sel_3, o__sel_4, o__sel_5, o__sel_6, o__sel_7;
  logic        o__sel_10, o__sel_13, o__sel_14, o__sel_15, o__sel_16, o__sel_19;
  logic [1:0]  o__sel_8, o__sel_9, o__sel_11, o__sel_12;
  logic [1:0]  o__sel_17, o__sel_18, o__sel_20, o__sel_21;
  logic [1:0]  o__rel_op1, o__rel_op2, o__rel_op3;

  int checks   = 0;
  int failures = 0;
  int low_cnt  = 0;
  bit mon_en   = 0;

  nested_ifs_cfg_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i__cfg_data  (cfg_data),
    .i__cfg_valid (cfg_valid),
    .i__cfg_last  (cfg_last),
    .o__cfg_ready (o__cfg_ready),
    .o__cfg_done  (o__cfg_done),
    .o__cfg_err   (o__cfg_err),
    .o__cfg_busy  (o__cfg_busy),
    .o__cfg_epoch (o__cfg_epoch),
    .o__cons_1    (o__cons_1),
    .o__cons_2    (o__cons_2),
    .o__cons_3    (o__cons_3),
    .o__cons_4    (o__cons_4),
    .o__cons_5    (o__cons_5),
    .o__cons_6    (o__cons_6),
    .o__cons_7    (o__cons_7),
    .o__cons_8    (o__cons_8),
    .o__cons_9    (o__cons_9),
    .o__cons_10   (o__cons_10),
    .o__cons_11   (o__cons_11),
    .o__sel_1     (o__sel_1),
    .o__sel_2     (o__sel_2),
    .o__sel_3     (o__sel_3),
    .o__sel_4     (o__sel_4),
    .o__sel_5     (o__sel_5),
    .o__sel_6     (o__sel_6),
    .o__sel_7     (o__sel_7),
    .o__sel_8     (o__sel_8),
    .o__sel_9     (o__sel_9),
    .o__sel_10    (o__sel_10),
    .o__sel_11    (o__sel_11),
    .o__sel_12    (o__sel_12),
    .o__sel_13    (o__sel_13),
    .o__sel_14    (o__sel_14),
    .o__sel_15    (o__sel_15),
    .o__sel_16    (o__sel_16),
    .o__sel_17    (o__sel_17),
    .o__sel_18    (o__sel_18),
    .o__sel_19    (o__sel_19),
    .o__sel_20    (o__sel_20),
    .o__sel_21    (o__sel_21),
    .o__rel_op1   (o__rel_op1),
    .o__rel_op2   (o__rel_op2),
    .o__rel_op3   (o__rel_op3)
  );

  // Outputs gathered into image-order vectors for compact comparison.
  logic [31:0] obs_cons [11];
  logic [31:0] obs_s1, obs_s2, obs_rel;
  assign obs_cons[0]  = o__cons_1;
  assign obs_cons[1]  = o__cons_2;
  assign obs_cons[2]  = o__cons_3;
  assign obs_cons[3]  = o__cons_4;
  assign obs_cons[4]  = o__cons_5;
  assign obs_cons[5]  = o__cons_6;
  assign obs_cons[6]  = o__cons_7;
  assign obs_cons[7]  = o__cons_8;
  assign obs_cons[8]  = o__cons_9;
  assign obs_cons[9]  = o__cons_10;
  assign obs_cons[10] = o__cons_11;
  assign obs_s1  = {19'b0, o__sel_19, o__sel_16, o__sel_15, o__sel_14, o__sel_13, o__sel_10,
                    o__sel_7, o__sel_6, o__sel_5, o__sel_4, o__sel_3, o__sel_2, o__sel_1};
  assign obs_s2  = {16'b0, o__sel_21, o__sel_20, o__sel_18, o__sel_17,
                    o__sel_12, o__sel_11, o__sel_9, o__sel_8};
  assign obs_rel = {26'b0, o__rel_op3, o__rel_op2, o__rel_op1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts cycles with ready low while the back-to-back run is active.
  always @(negedge clk) begin
    if (mon_en && rst_n && !o__cfg_ready) low_cnt++;
  end

  // Hard stop in case the run ever loses its way.
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the handshake.
  task automatic send_word(input logic [31:0] d, input logic l, input bit gaps);
    int n;
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    cfg_data  = d;
    cfg_last  = l;
    cfg_valid = 1'b1;
    n = 0;
    while (!o__cfg_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 32'(o__cfg_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  // Words 0..10 are base+k, then w11, w12; last asserted on index last_at.
  task automatic send_image(input logic [31:0] base, input logic [31:0] w11,
                            input logic [31:0] w12, input int n, input int last_at,
                            input bit gaps);
    logic [31:0] d;
    for (int k = 0; k < n; k++) begin
      d = (k < 11) ? base + 32'(k) : ((k == 11) ? w11 : w12);
      send_word(d, (k == last_at), gaps);
    end
  endtask

  // Sends a good image and checks the COMMIT cycle and the done cycle.
  task automatic commit_image(input string tag, input logic [31:0] base,
                              input logic [31:0] w11, input logic [31:0] w12,
                              input bit gaps, input logic [7:0] exp_epoch);
    send_image(base, w11, w12, 13, 12, gaps);
    check({tag, "_commit_ready"}, 32'(o__cfg_ready), 32'd0);
    check({tag, "_commit_done"},  32'(o__cfg_done),  32'd0);
    @(negedge clk);
    check({tag, "_done"},  32'(o__cfg_done),  32'd1);
    check({tag, "_epoch"}, 32'(o__cfg_epoch), 32'(exp_epoch));
  endtask

  task automatic check_cfg(input string tag, input bit zero, input logic [31:0] base,
                           input logic [31:0] s1, input logic [31:0] s2,
                           input logic [31:0] rel);
    for (int k = 0; k < 11; k++)
      check($sformatf("%s_cons_%0d", tag, k + 1), obs_cons[k], zero ? 32'd0 : base + 32'(k));
    check({tag, "_sel1b"}, obs_s1, s1);
    check({tag, "_sel2b"}, obs_s2, s2);
    check({tag, "_relop"}, obs_rel, rel);
  endtask

  task automatic check_idle_flags(input string tag, input logic [7:0] exp_epoch);
    check({tag, "_ready"}, 32'(o__cfg_ready), 32'd1);
    check({tag, "_busy"},  32'(o__cfg_busy),  32'd0);
    check({tag, "_done"},  32'(o__cfg_done),  32'd0);
    check({tag, "_err"},   32'(o__cfg_err),   32'd0);
    check({tag, "_epoch"}, 32'(o__cfg_epoch), 32'(exp_epoch));
  endtask

  task automatic do_reset();
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    cfg_data  = '0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    cfg_data  = '0;

    // Reset state.
    do_reset();
    check_idle_flags("rst", 8'd0);
    check_cfg("rst", 1'b1, 32'd0, 32'd0, 32'd0, 32'd0);

    // Full image: all selects at maximum, opcodes 1/2/3.
    send_image(32'h100, 32'h1FFF_FFFF, 32'h0000_0039, 13, 12, 1'b0);
    check("full_commit_ready", 32'(o__cfg_ready), 32'd0);
    check("full_commit_busy",  32'(o__cfg_busy),  32'd1);
    check("full_commit_old",   o__cons_1,         32'd0);
    @(negedge clk);
    check("full_done",  32'(o__cfg_done),  32'd1);
    check("full_epoch", 32'(o__cfg_epoch), 32'd1);
    check_cfg("full", 1'b0, 32'h100, 32'h1FFF, 32'hFFFF, 32'h39);
    @(negedge clk);
    check_idle_flags("full_after", 8'd1);

    // Early last on word 5.
    send_image(32'h900, 32'h0, 32'h0, 6, 5, 1'b0);
    check("early_err",   32'(o__cfg_err),   32'd1);
    check("early_busy",  32'(o__cfg_busy),  32'd0);
    check("early_done",  32'(o__cfg_done),  32'd0);
    check("early_epoch", 32'(o__cfg_epoch), 32'd1);
    check_cfg("early_keep", 1'b0, 32'h100, 32'h1FFF, 32'hFFFF, 32'h39);
    @(negedge clk);
    check("early_err_off", 32'(o__cfg_err), 32'd0);

    // Following good image: sel_1, sel_3 and sel_8 set; opcodes 0/1/2 with
    // junk in the ignored upper bits of word 12.
    commit_image("imgb", 32'h200, 32'h0000_6005, 32'hFFFF_FF24, 1'b0, 8'd2);
    check_cfg("imgb", 1'b0, 32'h200, 32'h0005, 32'h0003, 32'h24);

    // One-word image in IDLE.
    send_word(32'hDEAD_BEEF, 1'b1, 1'b0);
    check("oneword_err",  32'(o__cfg_err),  32'd1);
    check("oneword_busy", 32'(o__cfg_busy), 32'd0);

    // Missing last: error on word 12, then a fresh image from k=0.
    send_image(32'h300, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 13, -1, 1'b0);
    check("nolast_err",   32'(o__cfg_err),    32'd1);
    check("nolast_epoch", 32'(o__cfg_epoch),  32'd2);
    check_cfg("nolast_keep", 1'b0, 32'h200, 32'h0005, 32'h0003, 32'h24);
    commit_image("imgc", 32'h400, 32'h1FFF_FFFF, 32'h0000_0039, 1'b0, 8'd3);
    check_cfg("imgc", 1'b0, 32'h400, 32'h1FFF, 32'hFFFF, 32'h39);

    // Random valid gaps inside an image; each 2-bit select = 1, opcodes 1/3/2.
    commit_image("stall", 32'h500, 32'h0AAA_AAAA, 32'h0000_002D, 1'b1, 8'd4);
    check_cfg("stall", 1'b0, 32'h500, 32'h0AAA, 32'h5555, 32'h2D);

    // Reset asserted asynchronously while word 7 is being presented.
    send_image(32'h600, 32'h0, 32'h0, 7, -1, 1'b0);
    cfg_data  = 32'h607;
    cfg_valid = 1'b1;
    #2;
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    #1;
    check("midrst_async_cons1", o__cons_1, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_flags("midrst", 8'd0);
    check_cfg("midrst", 1'b1, 32'd0, 32'd0, 32'd0, 32'd0);
    commit_image("postrst", 32'h700, 32'h1FFF_FFFF, 32'h0000_0039, 1'b0, 8'd1);
    check_cfg("postrst", 1'b0, 32'h700, 32'h1FFF, 32'hFFFF, 32'h39);

    // 256 back-to-back images from a fresh reset; epoch wraps to 0 at the end.
    do_reset();
    mon_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      commit_image($sformatf("b2b%0d", i), 32'(i) << 12, 32'h1FFF_FFFF, 32'h39, 1'b0,
                   8'((i + 1) % 256));
    end
    mon_en = 1'b0;
    check("b2b_ready_low_cycles", 32'(low_cnt), 32'd256);
    check("b2b_epoch_wrap", 32'(o__cfg_epoch), 32'd0);
    check_cfg("b2b_last", 1'b0, 32'(255) << 12, 32'h1FFF, 32'hFFFF, 32'h39);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
